seq_sub64: RTL and testbench

SEQ_SUB64 -- requirements
Module: seq_sub64

---
 rtl/sub64_pkg.sv | 31 +++
 rtl/sub_slice.sv | 23 ++
 rtl/seq_sub64.sv | 164 ++++++++++++++++
 tb/tb_seq_sub64.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sub64_pkg.sv
// Shared definitions for the sequential 64-bit subtractor: operand width,
// FSM state encoding and the set of supported slice widths.
package sub64_pkg;

    // Full operand width; every slice width must divide it evenly.
    localparam int OP_W = 64;

    // Slice widths the datapath supports.
    localparam int N_LEGAL_SLICE_W = 4;
    localparam int LEGAL_SLICE_W [N_LEGAL_SLICE_W] = '{8, 16, 32, 64};

    // Control FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // True when w is one of the supported slice widths.
    function automatic bit is_legal_slice_w(input int w);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < N_LEGAL_SLICE_W; i++) begin
            if (LEGAL_SLICE_W[i] == w) begin
                ok = 1'b1;
            end
        end
        return ok;
    endfunction

endpackage : sub64_pkg

// File: rtl/sub_slice.sv
// Combinational W-bit subtract with borrow-in and borrow-out:
// {bout, d} = a - b - bin, with bout set when the true result is negative.
module sub_slice #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);

    logic [W:0] diff_ext;

    // Extend by one bit so the borrow lands in the MSB of the wide result.
    always_comb begin
        diff_ext = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    end

    assign d    = diff_ext[W-1:0];
    assign bout = diff_ext[W];

endmodule : sub_slice

// File: rtl/seq_sub64.sv
// Sequential 64-bit subtractor: computes a - b - bin one SLICE_W-bit slice
// per cycle, rippling the borrow between slices, with valid/ready handshakes
// on both sides. Result latency is 64/SLICE_W cycles from the accept edge.
// Optional feature: define SEQ_SUB64_OVF_EN to add the signed-overflow
// output ovf.
module seq_sub64
    import sub64_pkg::*;
#(
    parameter int SLICE_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    input  logic            bin,
    output logic [OP_W-1:0] diff,
    output logic            bout,
    output logic            out_valid,
    input  logic            out_ready
`ifdef SEQ_SUB64_OVF_EN
    ,
    output logic            ovf
`endif
);

    localparam int NSLICE = OP_W / SLICE_W;
    // A single-slice build still gets a 1-bit index so no zero-width vectors.
    localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    if (!is_legal_slice_w(SLICE_W)) begin : g_bad_slice_w
        $error("seq_sub64: SLICE_W must be 8, 16, 32 or 64");
    end

    state_t           state_q,  state_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic             borrow_q, borrow_d;
    logic [OP_W-1:0]  a_q,      a_d;
    logic [OP_W-1:0]  b_q,      b_d;
    logic [OP_W-1:0]  diff_q,   diff_d;
    logic             bout_q,   bout_d;
`ifdef SEQ_SUB64_OVF_EN
    logic             ovf_q,    ovf_d;
`endif

    logic [SLICE_W-1:0] a_slice;
    logic [SLICE_W-1:0] b_slice;
    logic [SLICE_W-1:0] d_slice;
    logic               slice_bout;

    // Select the operand slices addressed by the current index.
    always_comb begin
        a_slice = a_q[idx_q*SLICE_W +: SLICE_W];
        b_slice = b_q[idx_q*SLICE_W +: SLICE_W];
    end

    // The carried borrow feeds the slice; on the first slice it holds bin.
    sub_slice #(
        .W (SLICE_W)
    ) u_sub_slice (
        .a    (a_slice),
        .b    (b_slice),
        .bin  (borrow_q),
        .d    (d_slice),
        .bout (slice_bout)
    );

    // Next-state and datapath update for the IDLE -> CALC -> DONE sequence.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        state_d  = state_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
`ifdef SEQ_SUB64_OVF_EN
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    idx_d    = '0;
                    diff_d   = '0;
                    bout_d   = 1'b0;
`ifdef SEQ_SUB64_OVF_EN
                    ovf_d    = 1'b0;
`endif
                    state_d  = CALC;
                end
            end
            CALC: begin
                diff_d[idx_q*SLICE_W +: SLICE_W] = d_slice;
                borrow_d = slice_bout;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    bout_d  = slice_bout;
`ifdef SEQ_SUB64_OVF_EN
                    // Signed overflow: operand signs differ and the result
                    // sign (MSB of the last slice) differs from a's sign.
                    ovf_d   = (a_q[OP_W-1] != b_q[OP_W-1]) &&
                              (d_slice[SLICE_W-1] != a_q[OP_W-1]);
`endif
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
`ifdef SEQ_SUB64_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // flop samples the pre-edge values regardless of statement order.
            state_q  <= state_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
`ifdef SEQ_SUB64_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
`ifdef SEQ_SUB64_OVF_EN
    assign ovf       = ovf_q & out_valid;
`endif

endmodule : seq_sub64

// File: tb/tb_seq_sub64.sv
// Bench for seq_sub64: four instances (SLICE_W 8, 16, 32, 64) share the
// stimulus; each result is compared against hand-computed vectors, plus
// backpressure and mid-operation reset sequences.
module tb_seq_sub64;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        bin;
    logic [63:0] a;
    logic [63:0] b;

    logic [3:0]  ir;
    logic [3:0]  ov;
    logic [3:0]  bo;
    logic [63:0] dif [4];
`ifdef SEQ_SUB64_OVF_EN
    logic [3:0]  ovf_w;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int lat [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        seq_sub64 #(
            .SLICE_W (8 << g)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (ir[g]),
            .a         (a),
            .b         (b),
            .bin       (bin),
            .diff      (dif[g]),
            .bout      (bo[g]),
            .out_valid (ov[g]),
            .out_ready (out_ready)
`ifdef SEQ_SUB64_OVF_EN
            ,
            .ovf       (ovf_w[g])
`endif
        );
    end

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        bin;
        logic [63:0] d;
        logic        bo;
        logic        ovf;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present one operand set, then hold out_ready low for 12 cycles and
    // record, per instance, the cycle count until out_valid first rises.
    task automatic run_op(input logic [63:0] ta, input logic [63:0] tb, input logic tbin);
        @(negedge clk);
        a         = ta;
        b         = tb;
        bin       = tbin;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) lat[k] = -1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (lat[k] < 0 && ov[k]) lat[k] = c;
            end
        end
    endtask

    // Hand the result over and confirm every instance is back in IDLE.
    task automatic release_result(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ov_after_ready"}, 64'(ov), 64'h0);
        check({tag, "_ir_after_ready"}, 64'(ir), 64'hF);
`ifdef SEQ_SUB64_OVF_EN
        check({tag, "_ovf_idle"}, 64'(ovf_w), 64'h0);
`endif
    endtask

    initial begin
        logic seen_ov;

        vecs[0] = '{64'd998, 64'd128, 1'b0, 64'd870, 1'b0, 1'b0};
        vecs[1] = '{64'd128, 64'd998, 1'b0, 64'hFFFF_FFFF_FFFF_FC9A, 1'b1, 1'b0};
        vecs[2] = '{64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        vecs[3] = '{64'h0000_0000_0001_0000, 64'd1, 1'b0, 64'h0000_0000_0000_FFFF, 1'b0, 1'b0};
        vecs[4] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
        vecs[5] = '{64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0};
        vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        vecs[7] = '{64'h0000_0001_0000_0000, 64'd1, 1'b1, 64'h0000_0000_FFFF_FFFE, 1'b0, 1'b0};
        vecs[8] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b1};
        vecs[9] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 64'h0246_8ACF_1357_9BCF, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        bin       = 1'b0;
        a         = '0;
        b         = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_in_ready",  64'(ir), 64'hF);
        check("rst_out_valid", 64'(ov), 64'h0);
        check("rst_bout",      64'(bo), 64'h0);
        for (int k = 0; k < 4; k++) check($sformatf("rst_diff_w%0d", 8 << k), dif[k], 64'h0);
`ifdef SEQ_SUB64_OVF_EN
        check("rst_ovf", 64'(ovf_w), 64'h0);
`endif
        rst = 1'b0;

        // Table-driven vectors, applied to all four slice widths at once.
        for (int v = 0; v < 10; v++) begin
            run_op(vecs[v].a, vecs[v].b, vecs[v].bin);
            for (int k = 0; k < 4; k++) begin
                check($sformatf("v%0d_lat_w%0d",  v, 8 << k), 64'(lat[k]), 64'(8 >> k));
                check($sformatf("v%0d_diff_w%0d", v, 8 << k), dif[k], vecs[v].d);
                check($sformatf("v%0d_bout_w%0d", v, 8 << k), 64'(bo[k]), 64'(vecs[v].bo));
                check($sformatf("v%0d_ir_w%0d",   v, 8 << k), 64'(ir[k]), 64'h0);
`ifdef SEQ_SUB64_OVF_EN
                check($sformatf("v%0d_ovf_w%0d",  v, 8 << k), 64'(ovf_w[k]), 64'(vecs[v].ovf));
`endif
            end
            release_result($sformatf("v%0d", v));
        end

        // Backpressure in DONE with new operands offered.
        run_op(64'd998, 64'd128, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            a         = 64'd5;
            b         = 64'd3;
            bin       = 1'b1;
            out_ready = 1'b0;
            @(negedge clk);
            check($sformatf("bp%0d_diff", c), dif[1], 64'd870);
            check($sformatf("bp%0d_bout", c), 64'(bo[1]), 64'h0);
            check($sformatf("bp%0d_ov",   c), 64'(ov), 64'hF);
            check($sformatf("bp%0d_ir",   c), 64'(ir), 64'h0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_ov", 64'(ov), 64'h0);
        check("bp_release_ir", 64'(ir), 64'hF);
        @(negedge clk);
        check("bp_stay_idle",  64'(ir), 64'hF);
        check("bp_no_capture", dif[1], 64'd870);

        // Reset during the second CALC cycle aborts the operation.
        @(negedge clk);
        a        = 64'd12345;
        b        = 64'd345;
        bin      = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_ov",   64'(ov), 64'h0);
        check("abort_ir",   64'(ir), 64'hF);
        check("abort_diff", dif[1], 64'h0);
        check("abort_bout", 64'(bo), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        seen_ov = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (ov != 4'h0) seen_ov = 1'b1;
        end
        check("abort_no_pulse", 64'(seen_ov), 64'h0);

        run_op(64'd9998, 64'd9028, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("post_abort_diff_w%0d", 8 << k), dif[k], 64'd970);
            check($sformatf("post_abort_lat_w%0d",  8 << k), 64'(lat[k]), 64'(8 >> k));
            check($sformatf("post_abort_bout_w%0d", 8 << k), 64'(bo[k]), 64'h0);
        end
        release_result("post_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_seq_sub64
